data_cache_tag_assoc: RTL
=========================

Name: data_cache_tag_assoc

Overview:
- Parametrised N-way set-associative tag array for the write-allocate, write-back data cache. It is the successor of the direct-mapped tag RAM.
- Adds parallel tag compare, hit-way and victim-way selection (invalid-first, then tree pseudo-LRU), and a flush engine. The flush engine walks every line, hands dirty lines to the cache controller for write-back, and invalidates all lines.
- Sits between the data cache controller FSM and the data RAM; the controller owns the data array and memory traffic.

Parameters:
- WAYS, 2, associativity; power of two in {1,2,4,8}.
- INDEX_W, `DCACHE_INDEX, set index bits; SETS = 2**INDEX_W.
- TAG_W, `DTAGMSB-`DTAGLSB+1, tag bits per line.

Ports:
- clk  in  1  sole clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- lk_valid  in  1  lookup request.
- lk_index  in  INDEX_W  lookup set.
- lk_tag  in  TAG_W  lookup tag.
- lk_done  out  1  lookup result valid (registered).
- hit  out  1  tag match on a valid way.
- hit_way  out  WAYS_W  matching way; 0 on miss.
- victim_way  out  WAYS_W  replacement way for the looked-up set.
- victim_valid / victim_dirty  out  1 / 1  state of the victim line.
- victim_tag  out  TAG_W  tag of the victim line.
- we  in  1  tag write (fill or dirty update).
- wr_index  in  INDEX_W  write set.
- wr_way  in  WAYS_W  write way.
- valid_in / dirty_in  in  1 / 1  new line state.
- tag_in  in  TAG_W  new tag.
- flush_req  in  1  single-cycle pulse; starts a flush.
- wb_valid  out  1  dirty line presented for write-back.
- wb_ready  in  1  controller accepts the write-back.
- wb_index / wb_tag  out  INDEX_W / TAG_W  address of the dirty line.
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when the flush completes.

WAYS_W = max(1, log2(WAYS)).

Behaviour:
- Reset (rst_n=0 at posedge): all valid, dirty, tag and PLRU bits are cleared to 0. All outputs go to 0. Any flush in progress is aborted with no flush_done pulse.
- Storage: flop arrays indexed [set][way]. No RAM macro inference is required.
- Lookup, 1-cycle latency:
  - lk_valid with busy=0 at edge N gives lk_done=1 and the other lookup outputs at N+1.
  - lk_done is 0 in every other cycle, and all lookup outputs hold their previous values.
- Hit: exactly one valid way whose tag equals lk_tag. More than one matching way is illegal; it is an assertion failure, and the lowest-numbered way is reported.
- Victim selection: the lowest-numbered invalid way if one exists; otherwise the way pointed to by the tree PLRU. With WAYS=1 the victim is always way 0.
- PLRU update:
  - A hit updates the set's PLRU so that hit_way is most recently used.
  - A write with valid_in=1 updates the written way the same way.
  - A write with valid_in=0 leaves the PLRU unchanged.
- Same-cycle lookup and write:
  - The lookup samples pre-write contents (read-before-write).
  - If both target the same set, only the write's PLRU touch is applied.
- Writes: we updates tag, valid and dirty of [wr_index][wr_way] at the edge.
- While busy=1: we and lk_valid are ignored, and lk_done stays 0.
- Flush FSM, states IDLE -> SCAN -> WB_WAIT -> DONE -> IDLE:
  - IDLE: flush_req moves to SCAN and sets busy=1 from the next cycle. flush_req while busy is ignored.
  - SCAN: examines one line per cycle, ordered set-major (set 0 way 0 .. set SETS-1 way WAYS-1).
    - Valid and dirty line: moves to WB_WAIT and drives wb_valid=1 with wb_index and wb_tag.
    - Otherwise: clears the line's valid and dirty bits and advances.
  - WB_WAIT: wb_valid is held with stable wb_index and wb_tag until wb_ready=1. On that edge the line's valid and dirty bits are cleared, the scan advances, and the FSM returns to SCAN.
  - After the last line (wrap of the line counter): DONE for one cycle with flush_done=1, then IDLE with busy=0. All PLRU bits are cleared.
- Flush timing: with no dirty lines, a flush takes exactly SETS*WAYS SCAN cycles plus 1 DONE cycle.

Decomposition:
- Package dcache_tag_pkg:
  - flush_state_t enum.
  - WAYS_W derivation function.
  - PLRU bit count WAYS-1.
- Sub-module dcache_plru, combinational and parametrised by WAYS:
  - Given a set's tree bits, outputs the PLRU way.
  - Given the tree bits and a touched way, outputs the updated tree bits.
  - Instantiated twice: victim select, and update.

Test Plan:
- Reset, then lookup set 3 tag 0x5 -> lk_done=1 at the next edge, hit=0, victim_way=0, victim_valid=0.
- WAYS=2: write set 3 way 0 tag 0x5 valid, then way 1 tag 0x9 valid dirty; lookup tag 0x5 -> hit=1, hit_way=0. Next lookup of tag 0x7 -> victim_way=1, victim_dirty=1, victim_tag=0x9.
- Same cycle: write set 2 way 1 tag 0xA and lookup set 2 tag 0xA -> hit=0 (pre-write contents). Repeat the lookup the next cycle -> hit=1, hit_way=1.
- SETS=4, WAYS=2, dirty lines at (1,0) tag 0x3 and (3,1) tag 0x6, with wb_ready delayed 3 cycles each:
  - Two wb handshakes, in that order, with wb_index/wb_tag stable while waiting.
  - flush_done pulses once, after which all lines are invalid.
  - we and lk_valid asserted during the flush have no effect.
- Empty-cache flush -> busy high for exactly 8 cycles plus 1 DONE cycle, flush_done=1 in the DONE cycle.
- Reset asserted while in WB_WAIT -> next cycle busy=0, wb_valid=0, no flush_done, all lines invalid.

Source files
------------

// File: rtl/dcache_tag_pkg.sv
// Shared types and sizing helpers for the set-associative data cache tag array.
package dcache_tag_pkg;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_SCAN,
    FL_WB_WAIT,
    FL_DONE
  } flush_state_t;

  // Way-number width; a single-way cache still carries a 1-bit way field.
  function automatic int ways_w_f(input int ways);
    return (ways <= 2) ? 1 : $clog2(ways);
  endfunction

  // Tree PLRU needs WAYS-1 bits; keep one dummy bit for the direct-mapped case.
  function automatic int plru_bits_f(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/dcache_plru.sv
// Combinational tree pseudo-LRU: picks the LRU way and computes the tree after a touch.
module dcache_plru
  import dcache_tag_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WW = ways_w_f(WAYS),
  localparam int PB = plru_bits_f(WAYS)
) (
  input  logic [PB-1:0] tree,
  input  logic [WW-1:0] touch_way,
  output logic [WW-1:0] plru_way,
  output logic [PB-1:0] tree_next
);

  localparam int LEVELS = $clog2(WAYS);

  // Heap-ordered tree: node n has children 2n+1 / 2n+2, each bit points at the LRU half.
  always_comb begin
    logic on_path;
    int   node;
    on_path  = 1'b1;
    node     = 0;
    plru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      on_path = 1'b1;
      node    = 0;
      for (int l = 0; l < LEVELS; l++) begin
        if (tree[node] != w[LEVELS-1-l]) on_path = 1'b0;
        node = 2 * node + 1 + int'(w[LEVELS-1-l]);
      end
      if (on_path) plru_way = WW'(w);
    end
  end

  always_comb begin
    int node;
    node      = 0;
    tree_next = tree;
    for (int w = 0; w < WAYS; w++) begin
      if (touch_way == WW'(w)) begin
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
          tree_next[node] = ~w[LEVELS-1-l];
          node = 2 * node + 1 + int'(w[LEVELS-1-l]);
        end
      end
    end
  end

endmodule

// File: rtl/data_cache_tag_assoc.sv
// N-way tag array with parallel compare, invalid-first/PLRU victim choice and a flush engine.
module data_cache_tag_assoc
  import dcache_tag_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 8,
  localparam int WW     = ways_w_f(WAYS),
  localparam int PB     = plru_bits_f(WAYS),
  localparam int SETS   = 2 ** INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_valid,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_done,
  output logic               hit,
  output logic [WW-1:0]      hit_way,
  output logic [WW-1:0]      victim_way,
  output logic               victim_valid,
  output logic               victim_dirty,
  output logic [TAG_W-1:0]   victim_tag,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WW-1:0]      wr_way,
  input  logic               valid_in,
  input  logic               dirty_in,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               flush_req,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [INDEX_W-1:0] wb_index,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               busy,
  output logic               flush_done
);

  logic               valid_q [SETS][WAYS];
  logic               dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [PB-1:0]      plru_q  [SETS];

  flush_state_t       state_q, state_d;
  logic [INDEX_W-1:0] set_q;
  logic [WW-1:0]      way_q;

  logic               lk_fire, wr_fire;
  logic [WAYS-1:0]    match;
  logic               hit_c, inv_c;
  logic [WW-1:0]      hit_way_c, inv_way_c, plru_way, victim_c, unused_way;
  logic [PB-1:0]      lk_tree, wr_tree;
  logic               line_dirty, line_last, advance;

  assign lk_fire = lk_valid && !busy;
  assign wr_fire = we && !busy;

  // Descending scan so the lowest-numbered match / invalid way wins.
  always_comb begin
    match     = '0;
    hit_c     = 1'b0;
    hit_way_c = '0;
    inv_c     = 1'b0;
    inv_way_c = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = valid_q[lk_index][w] && (tag_q[lk_index][w] == lk_tag);
      if (match[w]) begin
        hit_c     = 1'b1;
        hit_way_c = WW'(w);
      end
      if (!valid_q[lk_index][w]) begin
        inv_c     = 1'b1;
        inv_way_c = WW'(w);
      end
    end
  end

  dcache_plru #(.WAYS(WAYS)) u_plru_lookup (
    .tree      (plru_q[lk_index]),
    .touch_way (hit_way_c),
    .plru_way  (plru_way),
    .tree_next (lk_tree)
  );

  dcache_plru #(.WAYS(WAYS)) u_plru_write (
    .tree      (plru_q[wr_index]),
    .touch_way (wr_way),
    .plru_way  (unused_way),
    .tree_next (wr_tree)
  );

  assign victim_c   = inv_c ? inv_way_c : plru_way;
  assign line_dirty = valid_q[set_q][way_q] && dirty_q[set_q][way_q];
  assign line_last  = (set_q == INDEX_W'(SETS - 1)) && (way_q == WW'(WAYS - 1));
  assign advance    = ((state_q == FL_SCAN) && !line_dirty) ||
                      ((state_q == FL_WB_WAIT) && wb_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
        plru_q[s] <= '0;
      end
    end else begin
      if (wr_fire) begin
        tag_q[wr_index][wr_way]   <= tag_in;
        valid_q[wr_index][wr_way] <= valid_in;
        dirty_q[wr_index][wr_way] <= dirty_in;
      end
      if (advance) begin
        valid_q[set_q][way_q] <= 1'b0;
        dirty_q[set_q][way_q] <= 1'b0;
      end
      // A write to the same set as a hitting lookup owns that set's PLRU update.
      if (state_q == FL_DONE) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else begin
        if (wr_fire && valid_in) plru_q[wr_index] <= wr_tree;
        if (lk_fire && hit_c && !(wr_fire && (wr_index == lk_index)))
          plru_q[lk_index] <= lk_tree;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_done      <= 1'b0;
      hit          <= 1'b0;
      hit_way      <= '0;
      victim_way   <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      lk_done <= lk_fire;
      if (lk_fire) begin
        hit          <= hit_c;
        hit_way      <= hit_way_c;
        victim_way   <= victim_c;
        victim_valid <= valid_q[lk_index][victim_c];
        victim_dirty <= dirty_q[lk_index][victim_c];
        victim_tag   <= tag_q[lk_index][victim_c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FL_IDLE;
      set_q    <= '0;
      way_q    <= '0;
      wb_index <= '0;
      wb_tag   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FL_IDLE) begin
        set_q <= '0;
        way_q <= '0;
      end else if (advance) begin
        if (way_q == WW'(WAYS - 1)) begin
          way_q <= '0;
          set_q <= set_q + 1'b1;
        end else begin
          way_q <= way_q + 1'b1;
        end
      end
      if ((state_q == FL_SCAN) && line_dirty) begin
        wb_index <= set_q;
        wb_tag   <= tag_q[set_q][way_q];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != FL_IDLE);
    wb_valid   = (state_q == FL_WB_WAIT);
    flush_done = (state_q == FL_DONE);
    unique case (state_q)
      FL_IDLE:    if (flush_req) state_d = FL_SCAN;
      FL_SCAN: begin
        if (line_dirty)     state_d = FL_WB_WAIT;
        else if (line_last) state_d = FL_DONE;
      end
      FL_WB_WAIT: if (wb_ready) state_d = line_last ? FL_DONE : FL_SCAN;
      FL_DONE:    state_d = FL_IDLE;
      default:    state_d = FL_IDLE;
    endcase
  end

  assert property (@(posedge clk) disable iff (!rst_n) lk_fire |-> $onehot0(match));

endmodule
